// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and geometry helpers for the conv layer sequencers
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    DRAIN  = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } conv_state_t;

  localparam int CONV1_IMG_W = 28;
  localparam int CONV1_KSIZE = 5;

  function automatic int out_w(input int img_w, input int ksize);
    return img_w - ksize + 1;
  endfunction

  function automatic int taps(input int ksize);
    return ksize * ksize;
  endfunction

  // Width of an index that must reach n-1; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CONV1_OUT_W = out_w(CONV1_IMG_W, CONV1_KSIZE);
  localparam int CONV1_TAPS  = taps(CONV1_KSIZE);

endpackage

// File: rtl/conv_window_counter.sv
// rtl/conv_window_counter.sv - nested kernel-tap (kc/kr) and output-pixel (col/row) counters
module conv_window_counter
  import conv_pkg::*;
#(
  parameter int KSIZE = 5,
  parameter int OUT_W = 24,
  localparam int KW = addr_w(KSIZE),
  localparam int OW = addr_w(OUT_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          tap_step,
  input  logic          pix_step,
  output logic [KW-1:0] kc,
  output logic [KW-1:0] kr,
  output logic [OW-1:0] col,
  output logic [OW-1:0] row,
  output logic          tap_last,
  output logic          pixel_last
);

  localparam logic [KW-1:0] K_MAX = KW'(KSIZE - 1);
  localparam logic [OW-1:0] O_MAX = OW'(OUT_W - 1);

  logic [KW-1:0] r_kc, r_kr;
  logic [OW-1:0] r_col, r_row;

  // Both counters wrap to zero on their last step, so a finished layer leaves them ready for the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kc  <= '0;
      r_kr  <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (clr) begin
      r_kc  <= '0;
      r_kr  <= '0;
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (tap_step) begin
        if (r_kc == K_MAX) begin
          r_kc <= '0;
          r_kr <= (r_kr == K_MAX) ? '0 : r_kr + 1'b1;
        end else begin
          r_kc <= r_kc + 1'b1;
        end
      end
      if (pix_step) begin
        if (r_col == O_MAX) begin
          r_col <= '0;
          r_row <= (r_row == O_MAX) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign kc         = r_kc;
  assign kr         = r_kr;
  assign col        = r_col;
  assign row        = r_row;
  assign tap_last   = (r_kr == K_MAX) && (r_kc == K_MAX);
  assign pixel_last = (r_row == O_MAX) && (r_col == O_MAX);

endmodule

// File: rtl/conv1_layer_sequencer.sv
// rtl/conv1_layer_sequencer.sv - walks one valid 2D conv layer: tap reads, MAC strobes, result handoff
module conv1_layer_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W   = CONV1_IMG_W,
  parameter int KSIZE   = CONV1_KSIZE,
  parameter int NUM_CH  = 2,
  parameter int MEM_LAT = 1,
  localparam int OUT_W  = out_w(IMG_W, KSIZE),
  localparam int IAW    = addr_w(IMG_W * IMG_W),
  localparam int WAW    = addr_w(taps(KSIZE)),
  localparam int OAW    = addr_w(OUT_W * OUT_W)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           img_rd_en,
  output logic [IAW-1:0] img_rd_addr,
  output logic [WAW-1:0] w_rd_addr,
  output logic           mac_en,
  output logic           mac_clr,
  output logic           wr_valid,
  input  logic           wr_ready,
  output logic [OAW-1:0] wr_addr
);

  localparam int KW = addr_w(KSIZE);
  localparam int OW = addr_w(OUT_W);
  localparam int DW = addr_w(MEM_LAT);

  if (MEM_LAT < 1 || NUM_CH < 1) begin : g_param_check
    $error("conv1_layer_sequencer: MEM_LAT and NUM_CH must be at least 1");
  end

  conv_state_t        r_state;
  logic               r_busy, r_done, r_img_rd_en, r_wr_valid;
  logic [DW-1:0]      r_drain;
  logic [MEM_LAT-1:0] r_en_sr, r_clr_sr;

  logic [KW-1:0] w_kc, w_kr;
  logic [OW-1:0] w_col, w_row;
  logic          w_tap_last, w_pixel_last;
  logic          w_accept, w_tap_step, w_pix_step, w_tap0;

  assign w_accept   = ((r_state == IDLE) || (r_state == FINISH)) && start;
  assign w_tap_step = (r_state == ISSUE);
  assign w_pix_step = (r_state == WRITE) && wr_ready;
  assign w_tap0     = (w_kr == '0) && (w_kc == '0);

  conv_window_counter #(
    .KSIZE(KSIZE),
    .OUT_W(OUT_W)
  ) u_win (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_accept),
    .tap_step  (w_tap_step),
    .pix_step  (w_pix_step),
    .kc        (w_kc),
    .kr        (w_kr),
    .col       (w_col),
    .row       (w_row),
    .tap_last  (w_tap_last),
    .pixel_last(w_pixel_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_img_rd_en <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_drain     <= '0;
    end else begin
      case (r_state)
        IDLE, FINISH: begin
          if (start) begin
            r_state     <= ISSUE;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_img_rd_en <= 1'b1;
          end
        end
        ISSUE: begin
          if (w_tap_last) begin
            r_state     <= DRAIN;
            r_img_rd_en <= 1'b0;
            r_drain     <= '0;
          end
        end
        DRAIN: begin
          // Wait out the read latency so the final tap's mac_en lands before wr_valid.
          if (r_drain == DW'(MEM_LAT - 1)) begin
            r_state    <= WRITE;
            r_wr_valid <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        WRITE: begin
          if (wr_ready) begin
            r_wr_valid <= 1'b0;
            if (w_pixel_last) begin
              r_state <= FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ISSUE;
              r_img_rd_en <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_img_rd_en <= 1'b0;
          r_wr_valid  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_sr  <= '0;
      r_clr_sr <= '0;
    end else begin
      r_en_sr[0]  <= r_img_rd_en;
      r_clr_sr[0] <= r_img_rd_en && w_tap0;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_en_sr[i]  <= r_en_sr[i-1];
        r_clr_sr[i] <= r_clr_sr[i-1];
      end
    end
  end

  assign img_rd_addr = (IAW'(w_row) + IAW'(w_kr)) * IAW'(IMG_W) + IAW'(w_col) + IAW'(w_kc);
  assign w_rd_addr   = WAW'(w_kr) * WAW'(KSIZE) + WAW'(w_kc);
  assign wr_addr     = OAW'(w_row) * OAW'(OUT_W) + OAW'(w_col);

  assign busy      = r_busy;
  assign done      = r_done;
  assign img_rd_en = r_img_rd_en;
  assign wr_valid  = r_wr_valid;
  assign mac_en    = r_en_sr[MEM_LAT-1];
  assign mac_clr   = r_clr_sr[MEM_LAT-1];

endmodule

// File: tb/tb_conv1_layer_sequencer.sv
// tb/tb_conv1_layer_sequencer.sv - directed self-checking bench for conv1_layer_sequencer
module tb_conv1_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, wr_ready;
  logic       busy, done, img_rd_en, mac_en, mac_clr, wr_valid;
  logic [9:0] img_rd_addr, wr_addr;
  logic [4:0] w_rd_addr;

  logic       start_3, wr_ready_3;
  logic       busy_3, done_3, img_rd_en_3, mac_en_3, mac_clr_3, wr_valid_3;
  logic [9:0] img_rd_addr_3, wr_addr_3;
  logic [4:0] w_rd_addr_3;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  conv1_layer_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .w_rd_addr(w_rd_addr),
    .mac_en(mac_en), .mac_clr(mac_clr), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr)
  );

  conv1_layer_sequencer #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start_3), .busy(busy_3), .done(done_3),
    .img_rd_en(img_rd_en_3), .img_rd_addr(img_rd_addr_3), .w_rd_addr(w_rd_addr_3),
    .mac_en(mac_en_3), .mac_clr(mac_clr_3), .wr_valid(wr_valid_3),
    .wr_ready(wr_ready_3), .wr_addr(wr_addr_3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, img_rd_en, 0);
    chk({tag, "_macen"}, mac_en, 0);
    chk({tag, "_macclr"}, mac_clr, 0);
    chk({tag, "_wrvalid"}, wr_valid, 0);
    chk({tag, "_imgaddr"}, img_rd_addr, 0);
    chk({tag, "_waddr"}, w_rd_addr, 0);
    chk({tag, "_wraddr"}, wr_addr, 0);
  endtask

  initial begin
    int t, n_mac, n_clr, n_hs, order_err, max_addr, done_cyc, idle_gaps;
    int first_mac, first_clr, last_mac, wv0, wv1, n_en3;

    reset = 1'b1; start = 1'b1; wr_ready = 1'b1;
    start_3 = 1'b0; wr_ready_3 = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset3_rden", img_rd_en_3, 0);
    start = 1'b0; reset = 1'b0;
    next_cyc();
    chk("start_with_reset_ignored", busy, 0);

    // first pixel: tap order, MAC strobe alignment, result timing
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; cyc = 1;
    chk("p0_busy", busy, 1);
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) next_cyc();
      chk($sformatf("p0_rden_c%0d", k), img_rd_en, 1);
      chk($sformatf("p0_imgaddr_c%0d", k), img_rd_addr, ((k - 1) / 5) * 28 + (k - 1) % 5);
      chk($sformatf("p0_waddr_c%0d", k), w_rd_addr, k - 1);
      if (k == 1) chk("p0_macen_c1", mac_en, 0);
      if (k == 2) begin
        chk("p0_macen_c2", mac_en, 1);
        chk("p0_macclr_c2", mac_clr, 1);
      end
      if (k == 3) chk("p0_macclr_c3", mac_clr, 0);
    end
    next_cyc();
    chk("p0_rden_c26", img_rd_en, 0);
    chk("p0_macen_c26", mac_en, 1);
    chk("p0_wrvalid_c26", wr_valid, 0);
    next_cyc();
    chk("p0_wrvalid_c27", wr_valid, 1);
    chk("p0_wraddr_c27", wr_addr, 0);
    chk("p0_macen_c27", mac_en, 0);

    // row wrap after pixel 23
    t = 0;
    do begin next_cyc(); t++; end while (!(wr_valid && wr_addr == 23) && t < 2000);
    chk("px23_cycle", cyc, 648);
    next_cyc();
    chk("row1_rden", img_rd_en, 1);
    chk("row1_imgaddr", img_rd_addr, 28);
    repeat (26) next_cyc();
    chk("px24_wrvalid", wr_valid, 1);
    chk("px24_wraddr", wr_addr, 24);

    // backpressure: hold wr_ready low across five WRITE cycles
    wr_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      next_cyc();
      chk($sformatf("bp_wrvalid_%0d", i), wr_valid, 1);
      chk($sformatf("bp_wraddr_%0d", i), wr_addr, 24);
      chk($sformatf("bp_rden_%0d", i), img_rd_en, 0);
      chk($sformatf("bp_macen_%0d", i), mac_en, 0);
    end
    wr_ready = 1'b1;
    next_cyc();
    chk("px25_first_addr", img_rd_addr, 29);
    next_cyc();
    next_cyc();
    start = 1'b1;
    next_cyc();
    start = 1'b0;
    chk("start_in_issue_addr", img_rd_addr, 32);
    chk("start_in_issue_busy", busy, 1);
    repeat (707 - 684) next_cyc();
    chk("px25_period_wrvalid", wr_valid, 1);
    chk("px25_wraddr", wr_addr, 25);

    // asynchronous reset in the middle of pixel 26
    repeat (3) next_cyc();
    reset = 1'b1;
    #1;
    chk("async_rst_rden", img_rd_en, 0);
    chk("async_rst_busy", busy, 0);
    next_cyc();
    chk_quiet("midrst");
    reset = 1'b0;
    repeat (3) next_cyc();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rden", img_rd_en, 0);

    // full layer from pixel 0
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; cyc = 1;
    n_mac = 0; n_clr = 0; n_hs = 0; order_err = 0; max_addr = 0; done_cyc = 0; idle_gaps = 0;
    while (cyc < 16000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) idle_gaps++;
      if (mac_en) n_mac++;
      if (mac_clr) n_clr++;
      if (img_rd_en && int'(img_rd_addr) > max_addr) max_addr = img_rd_addr;
      if (wr_valid && wr_ready) begin
        if (int'(wr_addr) != n_hs) order_err++;
        n_hs++;
      end
      next_cyc();
    end
    chk("layer_done_cycle", done_cyc, 15553);
    chk("layer_handshakes", n_hs, 576);
    chk("layer_order_errors", order_err, 0);
    chk("layer_mac_en", n_mac, 14400);
    chk("layer_mac_clr", n_clr, 576);
    chk("layer_max_imgaddr", max_addr, 783);
    chk("layer_busy_gaps", idle_gaps, 0);
    chk("finish_busy", busy, 0);
    repeat (5) next_cyc();
    chk("finish_done_held", done, 1);
    chk("finish_busy_held", busy, 0);
    chk("finish_rden", img_rd_en, 0);

    // restart from FINISH
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; cyc = 1;
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_rden", img_rd_en, 1);
    chk("restart_imgaddr", img_rd_addr, 0);
    repeat (26) next_cyc();
    chk("restart_wrvalid", wr_valid, 1);
    chk("restart_wraddr", wr_addr, 0);

    // MEM_LAT=3 instance
    start_3 = 1'b1;
    @(posedge clk); @(negedge clk);
    start_3 = 1'b0; cyc = 1;
    first_mac = 0; first_clr = 0; last_mac = 0; wv0 = 0; wv1 = 0; n_en3 = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) next_cyc();
      if (mac_en_3 && first_mac == 0) first_mac = k;
      if (mac_clr_3 && first_clr == 0) first_clr = k;
      if (mac_en_3 && k < 29) begin
        last_mac = k;
        n_en3++;
      end
      if (wr_valid_3 && wr_addr_3 == 0 && wv0 == 0) wv0 = k;
      if (wr_valid_3 && wr_addr_3 == 1 && wv1 == 0) wv1 = k;
    end
    chk("lat3_first_macen", first_mac, 4);
    chk("lat3_first_macclr", first_clr, 4);
    chk("lat3_last_macen", last_mac, 28);
    chk("lat3_macen_count", n_en3, 25);
    chk("lat3_wrvalid_px0", wv0, 29);
    chk("lat3_wrvalid_px1", wv1, 58);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
